br_unit: RTL and testbench

- Branch execution unit directly downstream of the branch reservation station.
- Accepts one issued branch/jump per cycle, resolves direction and target, and checks the front-end prediction.
- Buffers the result until the common data bus (CDB) arbiter grants it, then broadcasts link data and the resolution to the ROB.
- Two-stage elastic pipeline: E1 (resolve) and E2 (CDB hold).

---
 rtl/br_unit_if.sv | 40 ++++
 rtl/br_unit.sv | 156 +++++++++++++++
 tb/tb_br_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/br_unit_if.sv
// Issue-side and CDB-side signal bundle for the branch execution unit.
// master = RS/arbiter side, slave = br_unit.
interface br_unit_if #(
  parameter int ROB_IDX_W = 3,
  parameter int XLEN      = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_op;
  logic [XLEN-1:0]      in_q1;
  logic [XLEN-1:0]      in_q2;
  logic [XLEN-1:0]      in_imm;
  logic [XLEN-1:0]      in_pc;
  logic [ROB_IDX_W-1:0] in_rob;
  logic                 in_bp_taken;
  logic [XLEN-1:0]      in_bp_target;
  logic                 flush;
  logic                 cdb_req;
  logic                 cdb_grant;
  logic [ROB_IDX_W-1:0] cdb_rob;
  logic [XLEN-1:0]      cdb_data;
  logic                 cdb_rd_we;
  logic                 cdb_taken;
  logic [XLEN-1:0]      cdb_target;
  logic                 cdb_mispredict;

  modport master (
    output in_valid, in_op, in_q1, in_q2, in_imm, in_pc, in_rob,
           in_bp_taken, in_bp_target, flush, cdb_grant,
    input  in_ready, cdb_req, cdb_rob, cdb_data, cdb_rd_we, cdb_taken,
           cdb_target, cdb_mispredict
  );

  modport slave (
    input  in_valid, in_op, in_q1, in_q2, in_imm, in_pc, in_rob,
           in_bp_taken, in_bp_target, flush, cdb_grant,
    output in_ready, cdb_req, cdb_rob, cdb_data, cdb_rd_we, cdb_taken,
           cdb_target, cdb_mispredict
  );
endinterface

// File: rtl/br_unit.sv
// Branch execution unit: E1 resolves direction/target, E2 holds the result for the CDB.
// Optional macro BR_PERF_CNT_EN adds saturating resolved/mispredict counters.
module br_unit #(
  parameter int ROB_IDX_W = 3,
  parameter int XLEN      = 32
) (
  input  logic        clk,
  input  logic        rst,
  br_unit_if.slave    br
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0] perf_resolved,
  output logic [31:0] perf_mispredict
`endif
);

  localparam logic [3:0] OP_BEQ  = 4'd0;
  localparam logic [3:0] OP_BNE  = 4'd1;
  localparam logic [3:0] OP_BLT  = 4'd4;
  localparam logic [3:0] OP_BGE  = 4'd5;
  localparam logic [3:0] OP_BLTU = 4'd6;
  localparam logic [3:0] OP_BGEU = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;
  localparam logic [3:0] OP_JALR = 4'd9;

  logic                 s1_valid_q, s2_valid_q;
  logic [3:0]           s1_op_q;
  logic [XLEN-1:0]      s1_q1_q, s1_q2_q, s1_imm_q, s1_pc_q, s1_bp_target_q;
  logic [ROB_IDX_W-1:0] s1_rob_q;
  logic                 s1_bp_taken_q;

  logic [ROB_IDX_W-1:0] s2_rob_q;
  logic [XLEN-1:0]      s2_data_q, s2_target_q;
  logic                 s2_rd_we_q, s2_taken_q, s2_mispredict_q;

  logic                 taken_d, rd_we_d, is_jalr_d, mispredict_d;
  logic [XLEN-1:0]      target_d, data_d, pc_plus4, br_target, jalr_target;
  logic                 advance, transfer;

  assign advance     = !s2_valid_q | br.cdb_grant;
  assign br.in_ready = !s1_valid_q | advance;
  assign transfer    = br.in_valid & br.in_ready;

  assign pc_plus4    = s1_pc_q + XLEN'(4);
  assign br_target   = s1_pc_q + s1_imm_q;
  assign jalr_target = (s1_q1_q + s1_imm_q) & {{(XLEN-1){1'b1}}, 1'b0};

  // Illegal opcodes fall through as not-taken with no register write.
  always_comb begin
    taken_d   = 1'b0;
    rd_we_d   = 1'b0;
    is_jalr_d = 1'b0;
    case (s1_op_q)
      OP_BEQ:  taken_d = (s1_q1_q == s1_q2_q);
      OP_BNE:  taken_d = (s1_q1_q != s1_q2_q);
      OP_BLT:  taken_d = ($signed(s1_q1_q) <  $signed(s1_q2_q));
      OP_BGE:  taken_d = ($signed(s1_q1_q) >= $signed(s1_q2_q));
      OP_BLTU: taken_d = (s1_q1_q <  s1_q2_q);
      OP_BGEU: taken_d = (s1_q1_q >= s1_q2_q);
      OP_JAL: begin
        taken_d = 1'b1;
        rd_we_d = 1'b1;
      end
      OP_JALR: begin
        taken_d   = 1'b1;
        rd_we_d   = 1'b1;
        is_jalr_d = 1'b1;
      end
      default: taken_d = 1'b0;
    endcase
    target_d     = !taken_d ? pc_plus4 : (is_jalr_d ? jalr_target : br_target);
    data_d       = rd_we_d ? pc_plus4 : '0;
    mispredict_d = (taken_d != s1_bp_taken_q) |
                   (taken_d & (target_d != s1_bp_target_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q     <= 1'b0;
      s1_op_q        <= '0;
      s1_q1_q        <= '0;
      s1_q2_q        <= '0;
      s1_imm_q       <= '0;
      s1_pc_q        <= '0;
      s1_rob_q       <= '0;
      s1_bp_taken_q  <= 1'b0;
      s1_bp_target_q <= '0;
    end else if (br.flush) begin
      s1_valid_q <= 1'b0;
    end else if (transfer) begin
      s1_valid_q     <= 1'b1;
      s1_op_q        <= br.in_op;
      s1_q1_q        <= br.in_q1;
      s1_q2_q        <= br.in_q2;
      s1_imm_q       <= br.in_imm;
      s1_pc_q        <= br.in_pc;
      s1_rob_q       <= br.in_rob;
      s1_bp_taken_q  <= br.in_bp_taken;
      s1_bp_target_q <= br.in_bp_target;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // A grant in the same cycle as a load simply lets the new result overwrite E2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q      <= 1'b0;
      s2_rob_q        <= '0;
      s2_data_q       <= '0;
      s2_rd_we_q      <= 1'b0;
      s2_taken_q      <= 1'b0;
      s2_target_q     <= '0;
      s2_mispredict_q <= 1'b0;
    end else if (br.flush) begin
      s2_valid_q <= 1'b0;
    end else if (s1_valid_q & advance) begin
      s2_valid_q      <= 1'b1;
      s2_rob_q        <= s1_rob_q;
      s2_data_q       <= data_d;
      s2_rd_we_q      <= rd_we_d;
      s2_taken_q      <= taken_d;
      s2_target_q     <= target_d;
      s2_mispredict_q <= mispredict_d;
    end else if (br.cdb_grant) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign br.cdb_req        = s2_valid_q;
  assign br.cdb_rob        = s2_rob_q;
  assign br.cdb_data       = s2_data_q;
  assign br.cdb_rd_we      = s2_rd_we_q;
  assign br.cdb_taken      = s2_taken_q;
  assign br.cdb_target     = s2_target_q;
  assign br.cdb_mispredict = s2_mispredict_q;

`ifdef BR_PERF_CNT_EN
  logic perf_fire;
  assign perf_fire = s2_valid_q & br.cdb_grant & !br.flush;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_resolved   <= '0;
      perf_mispredict <= '0;
    end else if (perf_fire) begin
      if (perf_resolved != 32'hFFFF_FFFF)
        perf_resolved <= perf_resolved + 32'd1;
      if (s2_mispredict_q && (perf_mispredict != 32'hFFFF_FFFF))
        perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_unit.sv
// Self-checking bench for br_unit: directed scenarios plus random traffic against a queue-based model.
// Build with +define+BR_PERF_CNT_EN to also check the performance counters.
module tb_br_unit;
  localparam int ROB_IDX_W = 3;
  localparam int XLEN      = 32;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] q1, q2, imm, pc;
    logic [2:0]  rob;
    logic        bpt;
    logic [31:0] bptgt;
  } op_t;

  typedef struct {
    logic [2:0]  rob;
    logic [31:0] data;
    logic        rd_we;
    logic        taken;
    logic [31:0] target;
    logic        misp;
    int          stamp;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  br_unit_if #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) bus ();

`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_resolved, perf_mispredict;
`endif

  br_unit #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bus)
`ifdef BR_PERF_CNT_EN
    ,
    .perf_resolved   (perf_resolved),
    .perf_mispredict (perf_mispredict)
`endif
  );

  res_t        pend[$];
  int          now;
  int          vectors;
  int          miscompares;
  int unsigned perfResM, perfMisM;
  logic        dirEn;
  res_t        dirExp;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic [3:0] op, input logic [31:0] q1, q2, imm, pc,
                             input logic [2:0] rob, input logic bpt, input logic [31:0] bptgt);
    op_t o;
    o.op = op; o.q1 = q1; o.q2 = q2; o.imm = imm; o.pc = pc;
    o.rob = rob; o.bpt = bpt; o.bptgt = bptgt;
    return o;
  endfunction

  // Architectural meaning of each opcode, straight from the ISA rules.
  function automatic res_t refResult(input op_t o);
    res_t r;
    r.taken = 1'b0;
    r.rd_we = 1'b0;
    case (o.op)
      4'd0: r.taken = (o.q1 == o.q2);
      4'd1: r.taken = (o.q1 != o.q2);
      4'd4: r.taken = ($signed(o.q1) <  $signed(o.q2));
      4'd5: r.taken = ($signed(o.q1) >= $signed(o.q2));
      4'd6: r.taken = (o.q1 <  o.q2);
      4'd7: r.taken = (o.q1 >= o.q2);
      4'd8, 4'd9: begin r.taken = 1'b1; r.rd_we = 1'b1; end
      default: r.taken = 1'b0;
    endcase
    if (!r.taken)        r.target = o.pc + 32'd4;
    else if (o.op == 9)  r.target = (o.q1 + o.imm) & 32'hFFFF_FFFE;
    else                 r.target = o.pc + o.imm;
    r.data  = r.rd_we ? o.pc + 32'd4 : 32'd0;
    r.misp  = (r.taken != o.bpt) || (r.taken && (r.target != o.bptgt));
    r.rob   = o.rob;
    r.stamp = 0;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check just after, update the model at posedge.
  task automatic applyStimulus(input op_t o, input logic v, input logic g, input logic f,
                               output logic obsReady, output logic acc);
    logic expReady, expReq;
    res_t r;
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_op        = o.op;
    bus.in_q1        = o.q1;
    bus.in_q2        = o.q2;
    bus.in_imm       = o.imm;
    bus.in_pc        = o.pc;
    bus.in_rob       = o.rob;
    bus.in_bp_taken  = o.bpt;
    bus.in_bp_target = o.bptgt;
    bus.cdb_grant    = g;
    bus.flush        = f;
    #1;
    expReady = !(pend.size() == 2 && !g);
    expReq   = (pend.size() > 0) && (pend[0].stamp < now);
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("cdb_req", bus.cdb_req, expReq);
    if (expReq) begin
      checkOutput("cdb_rob", bus.cdb_rob, pend[0].rob);
      checkOutput("cdb_data", bus.cdb_data, pend[0].data);
      checkOutput("cdb_rd_we", bus.cdb_rd_we, pend[0].rd_we);
      checkOutput("cdb_taken", bus.cdb_taken, pend[0].taken);
      checkOutput("cdb_target", bus.cdb_target, pend[0].target);
      checkOutput("cdb_mispredict", bus.cdb_mispredict, pend[0].misp);
    end
    if (dirEn) begin
      checkOutput("dir_req", bus.cdb_req, 1);
      checkOutput("dir_taken", bus.cdb_taken, dirExp.taken);
      checkOutput("dir_target", bus.cdb_target, dirExp.target);
      checkOutput("dir_data", bus.cdb_data, dirExp.data);
      checkOutput("dir_rd_we", bus.cdb_rd_we, dirExp.rd_we);
      checkOutput("dir_mispredict", bus.cdb_mispredict, dirExp.misp);
      dirEn = 1'b0;
    end
`ifdef BR_PERF_CNT_EN
    checkOutput("perf_resolved", perf_resolved, perfResM);
    checkOutput("perf_mispredict", perf_mispredict, perfMisM);
`endif
    obsReady = bus.in_ready;
    acc      = v && bus.in_ready;
    @(posedge clk);
    now++;
    if (f) begin
      pend.delete();
    end else begin
      if (expReq && g) begin
        perfResM++;
        if (pend[0].misp) perfMisM++;
        void'(pend.pop_front());
      end
      if (v && expReady) begin
        r = refResult(o);
        r.stamp = now;
        pend.push_back(r);
      end
    end
  endtask

  task automatic idle(input logic g, input int n);
    logic rdy, acc;
    op_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) applyStimulus(z, 1'b0, g, 1'b0, rdy, acc);
  endtask

  task automatic directed(input op_t o, input logic tk, input logic [31:0] tgt, input logic [31:0] dat,
                          input logic we, input logic mp);
    logic rdy, acc;
    op_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(o, 1'b1, 1'b0, 1'b0, rdy, acc);
    checkOutput("dir_accept", acc, 1);
    applyStimulus(z, 1'b0, 1'b0, 1'b0, rdy, acc);
    dirExp.taken = tk; dirExp.target = tgt; dirExp.data = dat;
    dirExp.rd_we = we; dirExp.misp = mp;
    dirEn = 1'b1;
    applyStimulus(z, 1'b0, 1'b1, 1'b0, rdy, acc);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    checkOutput("pre_reset_req", bus.cdb_req, (pend.size() > 0) && (pend[0].stamp < now));
    rst = 1'b0;
    #1;
    checkOutput("reset_cdb_req", bus.cdb_req, 0);
    checkOutput("reset_cdb_data", bus.cdb_data, 0);
    checkOutput("reset_cdb_target", bus.cdb_target, 0);
`ifdef BR_PERF_CNT_EN
    checkOutput("reset_perf_resolved", perf_resolved, 0);
    checkOutput("reset_perf_mispredict", perf_mispredict, 0);
`endif
    pend.delete();
    perfResM = 0;
    perfMisM = 0;
    bus.in_valid  = 1'b0;
    bus.cdb_grant = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    op_t  o, z;
    op_t  bp[4];
    logic rdy, acc, v, g, f;
    int   k;

    vectors = 0; miscompares = 0; now = 0;
    perfResM = 0; perfMisM = 0; dirEn = 1'b0;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_q1 = '0; bus.in_q2 = '0;
    bus.in_imm = '0; bus.in_pc = '0; bus.in_rob = '0; bus.in_bp_taken = 1'b0;
    bus.in_bp_target = '0; bus.cdb_grant = 1'b0; bus.flush = 1'b0;

    doReset();
    idle(1'b0, 2);

    directed(mk(0, 5, 5, 32'h20, 32'h100, 1, 0, 0), 1, 32'h120, 0, 0, 1);
    directed(mk(9, 32'h1003, 0, 4, 32'h200, 2, 1, 32'h1006), 1, 32'h1006, 32'h204, 1, 0);
    directed(mk(6, 32'hFFFF_FFFF, 1, 32'h40, 32'h300, 3, 0, 0), 0, 32'h304, 0, 0, 0);
    directed(mk(4, 32'hFFFF_FFFF, 1, 32'h40, 32'h300, 4, 0, 0), 1, 32'h340, 0, 0, 1);
    directed(mk(3, 7, 7, 32'h40, 32'h400, 5, 1, 32'h404), 0, 32'h404, 0, 0, 1);
    directed(mk(8, 0, 0, 32'hFFFF_FFF0, 32'h8, 6, 1, 32'hFFFF_FFF8), 1, 32'hFFFF_FFF8, 32'hC, 1, 0);

    // Four back-to-back ops while the arbiter stalls for three cycles.
    for (int i = 0; i < 4; i++)
      bp[i] = mk(4'(i), 32'(i), 32'(i + 1), 32'h10 * 32'(i + 1), 32'h1000 + 32'(i * 4), 3'(i), 0, 0);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      g = (c >= 3);
      v = (k < 4);
      applyStimulus(v ? bp[k] : z, v, g, 1'b0, rdy, acc);
      if (c == 2) checkOutput("bp_ready_after_two", rdy, 0);
      if (acc) k++;
    end
    checkOutput("bp_all_accepted", k, 4);
    checkOutput("bp_drained_req", bus.cdb_req, 0);

    // Flush with both stages full, a grant and a new op all in the same cycle.
    applyStimulus(mk(0, 1, 1, 8, 32'h500, 1, 1, 32'h508), 1'b1, 1'b0, 1'b0, rdy, acc);
    applyStimulus(mk(1, 1, 2, 8, 32'h600, 2, 0, 0), 1'b1, 1'b0, 1'b0, rdy, acc);
    applyStimulus(mk(8, 0, 0, 8, 32'h700, 3, 1, 32'h708), 1'b1, 1'b1, 1'b1, rdy, acc);
    checkOutput("flush_ready_during", rdy, 1);
    idle(1'b1, 3);

    for (int c = 0; c < 400; c++) begin
      o.op    = 4'($urandom_range(0, 15));
      o.q1    = $urandom;
      o.q2    = ($urandom_range(0, 3) == 0) ? o.q1 : $urandom;
      o.imm   = $urandom;
      o.pc    = $urandom;
      o.rob   = 3'($urandom_range(0, 7));
      o.bpt   = 1'($urandom_range(0, 1));
      o.bptgt = ($urandom_range(0, 1) == 1) ? o.pc + o.imm : $urandom;
      v = ($urandom_range(0, 9) < 7);
      g = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 19) == 0);
      applyStimulus(o, v, g, f, rdy, acc);
    end
    idle(1'b1, 3);

    // Fresh counters, three granted ops with one misprediction, then reset mid-hold.
    doReset();
    directed(mk(0, 5, 5, 32'h20, 32'h100, 1, 1, 32'h120), 1, 32'h120, 0, 0, 0);
    directed(mk(1, 5, 5, 32'h20, 32'h100, 2, 1, 32'h120), 0, 32'h104, 0, 0, 1);
    directed(mk(8, 0, 0, 32'h40, 32'h100, 3, 1, 32'h140), 1, 32'h140, 32'h104, 1, 0);
    idle(1'b0, 1);
`ifdef BR_PERF_CNT_EN
    checkOutput("perf_resolved_three", perf_resolved, 3);
    checkOutput("perf_mispredict_one", perf_mispredict, 1);
`endif
    applyStimulus(mk(7, 9, 3, 32'h10, 32'h900, 4, 1, 32'h910), 1'b1, 1'b0, 1'b0, rdy, acc);
    idle(1'b0, 2);
    checkOutput("hold_req_before_reset", bus.cdb_req, 1);
    doReset();
    idle(1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
